// File: rtl/instruction_fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer.
// The text-memory width and the default start PC come from global macros;
// defaults are supplied here so the block stands alone.
`ifndef TEXT_BITS
`define TEXT_BITS 12
`endif
`ifndef INITIAL_PC
`define INITIAL_PC 32'h0040_0000
`endif

package instruction_fetch_buffer_pkg;

    // One prefetched instruction together with the PC it was fetched from.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam logic [31:0] FETCH_STEP = 32'd4;

endpackage

// File: rtl/instruction_fetch_buffer_fifo.sv
// Generic synchronous circular FIFO of fetch entries.
// Reset clears storage; flush only empties the queue (pointers and count).
// The caller guarantees push only when not full (or with a pop) and pop only when not empty.
module fetch_fifo
    import instruction_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         push,
    input  fetch_entry_t                 push_data,
    input  logic                         pop,
    output fetch_entry_t                 head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t      storage [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;

    assign head = storage[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties without touching storage.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) storage[i] <= '0;
        end else if (push && !flush) begin
            storage[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Instruction fetch stage: owns the fetch PC, reads the combinational text
// memory, queues {pc, inst} pairs and hands them to decode via valid/ready.
// A redirect flushes the queue and restarts fetch at the new PC.
`ifndef TEXT_BITS
`define TEXT_BITS 12
`endif
`ifndef INITIAL_PC
`define INITIAL_PC 32'h0040_0000
`endif

module instruction_fetch_buffer
    import instruction_fetch_buffer_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = `INITIAL_PC
) (
    input  logic                    clock,
    input  logic                    reset,
    output logic [`TEXT_BITS-3:0]   text_address,
    input  logic [31:0]             text_q,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    output logic                    inst_valid,
    output logic [31:0]             inst,
    output logic [31:0]             inst_pc,
    input  logic                    inst_ready
);

    localparam int             CW      = $clog2(DEPTH+1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [31:0]     fetch_pc;
    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    push_data;
    logic            pop;
    logic            push;

    assign pop       = inst_valid && inst_ready;
    assign push      = !redirect && ((count < DEPTH_C) || pop);
    assign push_data = '{pc: fetch_pc, inst: text_q};

    assign text_address = fetch_pc[`TEXT_BITS-1:2];
    assign inst_valid   = (count != '0);
    assign inst         = head.inst;
    assign inst_pc      = head.pc;

    // Fetch PC: reset beats redirect, redirect beats push; held while full without a pop.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc <= RESET_PC & 32'hFFFF_FFFC;
        end else if (redirect) begin
            fetch_pc <= redirect_pc & 32'hFFFF_FFFC;
        end else if (push) begin
            fetch_pc <= fetch_pc + FETCH_STEP;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .flush     (redirect),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Self-checking bench for instruction_fetch_buffer: directed scenarios then
// randomized traffic, all compared against a queue-based reference model.
`ifndef TEXT_BITS
`define TEXT_BITS 12
`endif

module tb_instruction_fetch_buffer;
    import instruction_fetch_buffer_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0040_0000;
    localparam int          TB    = `TEXT_BITS;

    logic            clock = 1'b0;
    logic            reset;
    logic            redirect;
    logic [31:0]     redirect_pc;
    logic            inst_ready;
    logic [TB-3:0]   text_address;
    logic [31:0]     text_q;
    logic            inst_valid;
    logic [31:0]     inst;
    logic [31:0]     inst_pc;

    always #5 clock = ~clock;

    // Text memory: word i holds 0x1000 + i.
    assign text_q = 32'h1000 + 32'(text_address);

    instruction_fetch_buffer #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .text_address (text_address),
        .text_q       (text_q),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .inst_valid   (inst_valid),
        .inst         (inst),
        .inst_pc      (inst_pc),
        .inst_ready   (inst_ready)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a plain queue of entries plus the fetch PC.
    fetch_entry_t  mq[$];
    logic [31:0]   m_pc;
    bit            known = 1'b0;
    logic [31:0]   amask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'h1000 + ((pc >> 2) & amask);
    endfunction

    // Compare the current outputs to the model, advance the model with the
    // current inputs, then step one clock.
    task automatic cycle();
        bit          m_pop;
        bit          m_push;
        if (known) begin
            chk("inst_valid", 32'(inst_valid), 32'(mq.size() != 0));
            chk("text_address", 32'(text_address), (m_pc >> 2) & amask);
            chk("count", 32'(dut.count), 32'(mq.size()));
            if (mq.size() != 0) begin
                chk("inst_pc", inst_pc, mq[0].pc);
                chk("inst", inst, mq[0].inst);
            end
        end
        if (reset) begin
            mq.delete();
            m_pc  = RPC;
            known = 1'b1;
        end else if (redirect) begin
            mq.delete();
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            m_pop  = (mq.size() != 0) && inst_ready;
            m_push = (mq.size() < DEPTH) || m_pop;
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back('{pc: m_pc, inst: word_at(m_pc)});
                m_pc = m_pc + 32'd4;
            end
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        amask       = (32'd1 << (TB - 2)) - 32'd1;
        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b1;
        @(negedge clock);

        // Reset state and free-run.
        do_reset();
        chk("rst_inst", inst, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_valid", 32'(inst_valid), 32'h0);
        chk("rst_taddr", 32'(text_address), (RPC >> 2) & amask);
        cycle();
        chk("first_valid", 32'(inst_valid), 32'h1);
        chk("first_pc", inst_pc, 32'h0040_0000);
        chk("first_inst", inst, 32'h1000);
        cycle();
        chk("second_pc", inst_pc, 32'h0040_0004);
        chk("second_inst", inst, 32'h1001);
        repeat (6) cycle();

        // Backpressure from reset: queue fills, fetch PC holds at RESET_PC+16.
        do_reset();
        inst_ready = 1'b0;
        repeat (10) cycle();
        chk("bp_count", 32'(dut.count), 32'd4);
        chk("bp_taddr", 32'(text_address), ((RPC + 32'd16) >> 2) & amask);
        chk("bp_head", inst_pc, RPC);

        // Full plus pop for one cycle.
        inst_ready = 1'b1;
        cycle();
        inst_ready = 1'b0;
        chk("fp_count", 32'(dut.count), 32'd4);
        chk("fp_taddr", 32'(text_address), ((RPC + 32'd20) >> 2) & amask);
        chk("fp_head", inst_pc, RPC + 32'd4);
        repeat (2) cycle();
        inst_ready = 1'b1;
        repeat (8) cycle();

        // Redirect in a steady stream; low bits of the target ignored.
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0103;
        cycle();
        redirect = 1'b0;
        chk("rd_valid0", 32'(inst_valid), 32'h0);
        cycle();
        chk("rd_valid1", 32'(inst_valid), 32'h1);
        chk("rd_pc", inst_pc, 32'h0040_0100);
        chk("rd_inst", inst, 32'h1040);
        repeat (5) cycle();

        // Redirect with the queue full and a pop: the flush wins.
        inst_ready = 1'b0;
        repeat (6) cycle();
        inst_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0200;
        cycle();
        redirect = 1'b0;
        chk("rfp_valid", 32'(inst_valid), 32'h0);
        chk("rfp_count", 32'(dut.count), 32'h0);
        cycle();
        chk("rfp_pc", inst_pc, 32'h0040_0200);
        repeat (3) cycle();

        // Reset during a redirect: reset wins.
        reset       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0040_0300;
        cycle();
        reset    = 1'b0;
        redirect = 1'b0;
        chk("rr_valid", 32'(inst_valid), 32'h0);
        chk("rr_taddr", 32'(text_address), (RPC >> 2) & amask);
        cycle();
        chk("rr_pc", inst_pc, RPC);
        repeat (3) cycle();

        // PC wrap at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        cycle();
        redirect = 1'b0;
        chk("wr_taddr0", 32'(text_address), amask);
        cycle();
        chk("wr_pc0", inst_pc, 32'hFFFF_FFFC);
        chk("wr_taddr1", 32'(text_address), 32'h0);
        cycle();
        chk("wr_pc1", inst_pc, 32'h0000_0000);
        chk("wr_inst1", inst, 32'h1000);
        repeat (4) cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 149) == 0);
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                      : $urandom;
            inst_ready  = ($urandom_range(0, 3) != 0);
            if (i % 400 < 40) inst_ready = 1'b0;
            cycle();
        end
        reset    = 1'b0;
        redirect = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit in case the clocking ever stalls.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete, checks %0d", checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_fetch_buffer.md
# instruction_fetch_buffer

Instruction fetch stage sitting directly downstream of the text memory and upstream of decode. It owns the fetch PC and drives the word address into the text memory, whose read is combinational. It captures the returned instruction word together with its PC into a small prefetch queue and hands entries to decode over a valid/ready handshake. Control-flow redirects flush the queue and restart fetch at the new PC.

## Interface
Parameters:
- `DEPTH`, default 4: queue entries; power of two, at least 2.
- `RESET_PC`, default `` `INITIAL_PC ``: fetch PC after reset.

Ports:
- `clock` in 1: single clock, all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `text_address` out `` `TEXT_BITS-2 ``: word address to the text memory, equal to `fetch_pc[`TEXT_BITS-1:2]`.
- `text_q` in 32: instruction word from the text memory, valid in the same cycle as `text_address`.
- `redirect` in 1: flush and restart fetch.
- `redirect_pc` in 32: new fetch PC; bits [1:0] are ignored and treated as 0.
- `inst_valid` out 1: queue head is valid.
- `inst` out 32: instruction word at the queue head.
- `inst_pc` out 32: PC of the queue head.
- `inst_ready` in 1: decode accepts the head this cycle.

## Operation
- State: `fetch_pc` (32 bit, bits [1:0] always 0), circular queue of {pc, inst} entries, read pointer, write pointer, `count` (width `$clog2(DEPTH+1)`).
- pop = `inst_valid && inst_ready`.
- push = `!redirect && (count < DEPTH || pop)`. Push writes {`fetch_pc`, `text_q`} at the write pointer and sets `fetch_pc` to `fetch_pc + 4`.
- `fetch_pc` is held when the queue is full and no pop occurs. `text_address` still reflects `fetch_pc`, and the memory is re-read harmlessly.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Redirect has priority over everything:
  - next count is 0;
  - both pointers are set to 0;
  - `fetch_pc` is set to `{redirect_pc[31:2], 2'b00}`;
  - no push occurs.
  - A pop in the same cycle counts as accepted by decode; the entry is discarded from the queue either way.
- Reset has priority over redirect:
  - `fetch_pc` = `RESET_PC`;
  - `count` and pointers = 0;
  - all queue storage cleared to 0.
  - Reset asserted mid-stream discards all queued entries.
- Outputs:
  - `inst_valid` = (`count != 0`).
  - `inst` and `inst_pc` always show the head entry's storage, including when invalid.
- Wrap-around:
  - `fetch_pc + 4` wraps modulo 2^32.
  - `text_address` drops the upper PC bits, so fetch wraps within the text memory.
  - Pointers wrap modulo `DEPTH`.

## Timing
- Reset values: `inst_valid` 0, `inst` 0, `inst_pc` 0, `text_address` = `RESET_PC[`TEXT_BITS-1:2]`.
- The first cycle after reset deasserts pushes `RESET_PC`. `inst_valid` rises one cycle later.
- Fetch-to-decode latency is 1 cycle, since the head is registered.
- Throughput is 1 instruction per cycle with `inst_ready` held high. There are no bubbles when full with a simultaneous pop.
- Redirect asserted in cycle N:
  - cycle N+1: `inst_valid` is 0 and the fetch of `redirect_pc` is pushed;
  - cycle N+2: `inst_valid` is 1 with `inst_pc` = `redirect_pc`.
- Back-to-back redirects: the last one wins, and no entry from an earlier redirect target ever becomes valid.

## Structure
- Shared package:
  - `fetch_entry_t` typedef, a packed struct {`logic [31:0] pc`, `logic [31:0] inst`};
  - `FETCH_STEP` = 4.
- Sub-module `fetch_fifo`: generic synchronous circular FIFO of `fetch_entry_t`.
  - Ports: `clock`, `reset`, `flush`, `push`, `push_data`, `pop`, `head`, `count`.
  - Parameterised by `DEPTH`.
- The top level holds `fetch_pc`, the push/pop/redirect logic, and the output mapping.

## Test plan
- **Reset and free-run:** text memory word i = 0x1000+i, `RESET_PC` = 0x00400000, `inst_ready` = 1.
  - Required: the first valid head is pc 0x00400000 / inst 0x1000, then pc 0x00400004 / inst 0x1001, one per cycle, no gaps.
- **Backpressure:** `inst_ready` = 0 for 10 cycles.
  - Required: `count` saturates at 4 and `fetch_pc` holds at `RESET_PC` + 16.
  - After `inst_ready` = 1, heads come out in order with no duplicate or skipped PC.
- **Full plus pop:** with the queue full, `inst_ready` = 1 for one cycle.
  - Required: `count` stays 4, one entry leaves, one is pushed, and `fetch_pc` advances by 4.
- **Redirect:** in a steady stream, assert `redirect` with `redirect_pc` = 0x00400103.
  - Required: the next cycle has `inst_valid` = 0; the cycle after has `inst_pc` = 0x00400100.
  - No stale PCs appear afterwards.
- **Simultaneous events:**
  - redirect plus pop plus full: required result is the flush.
  - Reset asserted during a redirect: required result is `fetch_pc` = `RESET_PC` and `inst_valid` = 0 for one cycle.
- **Wrap:** `redirect_pc` = 0xFFFFFFFC.
  - Required: the following entry has `inst_pc` = 0x00000000, and `text_address` wraps to 0.
